// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the ID/EX stage.
package pipe_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned RADDR_W = 5;

   // Decoded control bits carried down the pipe
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
   } ctrl_t;

   // A bubble never writes anything
   localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection against the registered EX slot.
module load_use_detect #(
   parameter int unsigned RADDR_W = 5
) (
   input  logic               id_valid,
   input  logic               id_uses_rs1,
   input  logic               id_uses_rs2,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic               ex_valid,
   input  logic               ex_mem_read,
   input  logic [RADDR_W-1:0] ex_rd,
   output logic               hazard
);

   logic rs1_match;
   logic rs2_match;

   // A load into x0 produces nothing a consumer could wait for
   always_comb begin
      rs1_match = id_uses_rs1 && (ex_rd == id_rs1);
      rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
      hazard    = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                  (rs1_match || rs2_match);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int unsigned XLEN    = pipe_pkg::XLEN,
   parameter int unsigned RADDR_W = pipe_pkg::RADDR_W,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic               id_reg_write,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic               id_uses_rs1,
   input  logic               id_uses_rs2,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic [XLEN-1:0]    id_rs1_data,
   input  logic [XLEN-1:0]    id_rs2_data,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [XLEN-1:0]    id_pc,
   input  logic               flush,
   input  logic               ex_hold,
   output logic               id_stall,
   output logic               ex_valid,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic [RADDR_W-1:0] ex_rs1,
   output logic [RADDR_W-1:0] ex_rs2,
   output logic [RADDR_W-1:0] ex_rd,
   output logic [XLEN-1:0]    ex_rs1_data,
   output logic [XLEN-1:0]    ex_rs2_data,
   output logic [XLEN-1:0]    ex_imm,
   output logic [XLEN-1:0]    ex_pc,
   output logic [CNT_W-1:0]   bubble_cnt
);

   logic               hazard;
   ctrl_t              ctrl_d;
   logic               valid_d;
   logic [RADDR_W-1:0] rs1_d;
   logic [RADDR_W-1:0] rs2_d;
   logic [RADDR_W-1:0] rd_d;
   logic [XLEN-1:0]    rs1_data_d;
   logic [XLEN-1:0]    rs2_data_d;
   logic [XLEN-1:0]    imm_d;
   logic [XLEN-1:0]    pc_d;
   logic [CNT_W-1:0]   cnt_d;

   load_use_detect #(
      .RADDR_W (RADDR_W)
   ) u_load_use_detect (
      .id_valid    (id_valid),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .hazard      (hazard)
   );

   // Front-end freeze: flush wins over hold and hazard; forced low in reset
   always_comb begin
      id_stall = !rst && !flush && (ex_hold || hazard);
   end

   // Next EX contents by priority: flush, hold, hazard bubble, normal load
   always_comb begin
      valid_d    = ex_valid;
      ctrl_d     = '{reg_write: ex_reg_write, mem_read: ex_mem_read,
                     mem_write: ex_mem_write};
      rs1_d      = ex_rs1;
      rs2_d      = ex_rs2;
      rd_d       = ex_rd;
      rs1_data_d = ex_rs1_data;
      rs2_data_d = ex_rs2_data;
      imm_d      = ex_imm;
      pc_d       = ex_pc;
      cnt_d      = bubble_cnt;
      if (flush || (!ex_hold && hazard)) begin
         valid_d    = 1'b0;
         ctrl_d     = BUBBLE_CTRL;
         rs1_d      = '0;
         rs2_d      = '0;
         rd_d       = '0;
         rs1_data_d = '0;
         rs2_data_d = '0;
         imm_d      = '0;
         pc_d       = '0;
         // Only load-use bubbles are counted
         if (!flush && bubble_cnt != '1) begin
            cnt_d = bubble_cnt + CNT_W'(1);
         end
      end else if (!ex_hold) begin
         valid_d    = id_valid;
         // Invalid slots must never carry write enables
         ctrl_d     = '{reg_write: id_reg_write && id_valid,
                        mem_read:  id_mem_read  && id_valid,
                        mem_write: id_mem_write && id_valid};
         rs1_d      = id_rs1;
         rs2_d      = id_rs2;
         rd_d       = id_rd;
         rs1_data_d = id_rs1_data;
         rs2_data_d = id_rs2_data;
         imm_d      = id_imm;
         pc_d       = id_pc;
      end
   end

   // EX register bank and bubble counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_pc        <= '0;
         bubble_cnt   <= '0;
      end else begin
         ex_valid     <= valid_d;
         ex_reg_write <= ctrl_d.reg_write;
         ex_mem_read  <= ctrl_d.mem_read;
         ex_mem_write <= ctrl_d.mem_write;
         ex_rs1       <= rs1_d;
         ex_rs2       <= rs2_d;
         ex_rd        <= rd_d;
         ex_rs1_data  <= rs1_data_d;
         ex_rs2_data  <= rs2_data_d;
         ex_imm       <= imm_d;
         ex_pc        <= pc_d;
         bubble_cnt   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (4-bit bubble counter).
module tb_id_ex_stage;

   logic        clk;
   logic        rst;
   logic        id_valid, id_reg_write, id_mem_read, id_mem_write;
   logic        id_uses_rs1, id_uses_rs2;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic        flush, ex_hold;
   logic        id_stall;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
   logic [3:0]  bubble_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(
      .CNT_W (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .id_mem_write (id_mem_write),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .id_rs1_data  (id_rs1_data),
      .id_rs2_data  (id_rs2_data),
      .id_imm       (id_imm),
      .id_pc        (id_pc),
      .flush        (flush),
      .ex_hold      (ex_hold),
      .id_stall     (id_stall),
      .ex_valid     (ex_valid),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_rd        (ex_rd),
      .ex_rs1_data  (ex_rs1_data),
      .ex_rs2_data  (ex_rs2_data),
      .ex_imm       (ex_imm),
      .ex_pc        (ex_pc),
      .bubble_cnt   (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                        input logic u1, input logic u2,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc);
      id_valid     = v;
      id_reg_write = rw;
      id_mem_read  = mr;
      id_mem_write = mw;
      id_uses_rs1  = u1;
      id_uses_rs2  = u2;
      id_rs1       = r1;
      id_rs2       = r2;
      id_rd        = rd;
      id_rs1_data  = d1;
      id_rs2_data  = d2;
      id_imm       = imm;
      id_pc        = pc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      ex_hold = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      #2;
      chk("rst_ex_valid", 32'(ex_valid), 0);
      chk("rst_cnt", 32'(bubble_cnt), 0);
      chk("rst_stall", 32'(id_stall), 0);
      step();
      step();
      rst = 1'b0;

      // R-type rd=5, then an independent instruction
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd5,
            32'h11, 32'h22, 32'h33, 32'h100);
      #1;
      chk("rtype_stall", 32'(id_stall), 0);
      step();
      chk("rtype_valid", 32'(ex_valid), 1);
      chk("rtype_rw", 32'(ex_reg_write), 1);
      chk("rtype_mr", 32'(ex_mem_read), 0);
      chk("rtype_rd", 32'(ex_rd), 5);
      chk("rtype_rs2", 32'(ex_rs2), 2);
      chk("rtype_d1", ex_rs1_data, 32'h11);
      chk("rtype_imm", ex_imm, 32'h33);
      chk("rtype_pc", ex_pc, 32'h100);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd6,
            32'h44, 32'h55, 32'h66, 32'h104);
      #1;
      chk("indep_stall", 32'(id_stall), 0);
      step();
      chk("indep_rd", 32'(ex_rd), 6);
      chk("indep_pc", ex_pc, 32'h104);
      chk("indep_d2", ex_rs2_data, 32'h55);

      // Load rd=5 then R-type reading rs2=5: one bubble
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd5,
            32'h1, 32'h2, 32'h8, 32'h108);
      #1;
      chk("load_stall", 32'(id_stall), 0);
      step();
      chk("load_mr", 32'(ex_mem_read), 1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd5, 5'd7,
            32'h77, 32'h88, 32'h99, 32'h10c);
      #1;
      chk("lu_stall", 32'(id_stall), 1);
      step();
      chk("bub_valid", 32'(ex_valid), 0);
      chk("bub_rw", 32'(ex_reg_write), 0);
      chk("bub_mr", 32'(ex_mem_read), 0);
      chk("bub_pc", ex_pc, 0);
      chk("bub_cnt", 32'(bubble_cnt), 1);
      chk("bub_stall", 32'(id_stall), 0);
      step();
      chk("after_valid", 32'(ex_valid), 1);
      chk("after_rd", 32'(ex_rd), 7);
      chk("after_pc", ex_pc, 32'h10c);
      chk("after_cnt", 32'(bubble_cnt), 1);

      // Load into x0, consumer of x0: no hazard
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0,
            0, 0, 0, 32'h110);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd8,
            0, 0, 0, 32'h114);
      #1;
      chk("x0_stall", 32'(id_stall), 0);
      step();
      chk("x0_valid", 32'(ex_valid), 1);
      chk("x0_pc", ex_pc, 32'h114);
      chk("x0_cnt", 32'(bubble_cnt), 1);

      // Mid-cycle reset during a load-use stall
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd0, 5'd5,
            0, 0, 0, 32'h118);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd10,
            0, 0, 0, 32'h11c);
      #1;
      chk("pre_rst_stall", 32'(id_stall), 1);
      #1;
      rst = 1'b1;
      #1;
      chk("mrst_valid", 32'(ex_valid), 0);
      chk("mrst_mr", 32'(ex_mem_read), 0);
      chk("mrst_rd", 32'(ex_rd), 0);
      chk("mrst_pc", ex_pc, 0);
      chk("mrst_cnt", 32'(bubble_cnt), 0);
      chk("mrst_stall", 32'(id_stall), 0);
      #1;
      rst = 1'b0;
      step();
      chk("post_rst_pc", ex_pc, 32'h11c);
      chk("post_rst_cnt", 32'(bubble_cnt), 0);

      // Hazard with flush: bubble, no stall, no count
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd9,
            0, 0, 0, 32'h120);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 5'd0, 5'd11,
            32'hab, 0, 0, 32'h124);
      flush = 1'b1;
      #1;
      chk("flush_stall", 32'(id_stall), 0);
      step();
      flush = 1'b0;
      chk("flush_valid", 32'(ex_valid), 0);
      chk("flush_rw", 32'(ex_reg_write), 0);
      chk("flush_cnt", 32'(bubble_cnt), 0);
      step();
      chk("reload_pc", ex_pc, 32'h124);

      // Hold for three cycles
      ex_hold = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd12,
            0, 0, 0, 32'h128);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_stall", 32'(id_stall), 1);
         step();
         chk("hold_pc", ex_pc, 32'h124);
         chk("hold_rd", 32'(ex_rd), 11);
      end
      chk("hold_cnt", 32'(bubble_cnt), 0);
      ex_hold = 1'b0;
      step();
      chk("unhold_pc", ex_pc, 32'h128);
      chk("unhold_mw", 32'(ex_mem_write), 1);

      // Repeated load-use pairs: counter saturates at 15
      for (int i = 1; i <= 17; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd3,
               0, 0, 0, 32'h200);
         step();
         drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd0, 5'd4,
               0, 0, 0, 32'h204);
         step();
         step();
         chk("sat_cnt", 32'(bubble_cnt), (i > 15) ? 15 : i);
      end

      // Invalid slot carries no write enables
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd13,
            0, 0, 0, 32'h300);
      step();
      chk("inv_valid", 32'(ex_valid), 0);
      chk("inv_rw", 32'(ex_reg_write), 0);
      chk("inv_mw", 32'(ex_mem_write), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
